bcd_counter_n: RTL and testbench
================================

# bcd_counter_n

Parametrised multi-digit synchronous BCD counter. It generalises the single-decade 7490-style counter to N cascaded decades with enable, parallel load, sticky overflow and a cascade carry output. Optional up/down counting is compiled in by macro. It is the counting core for timer, frequency-meter and display-driver blocks in the same design, and feeds seven-segment decoders directly through its packed digit bus.

## Interface
- `DIGITS`, default 4: number of BCD decades, 1..8.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: count enable; one step per clock while high.
- `load`, input, 1: synchronous parallel load.
- `d`, input, 4*DIGITS: load value, digit 0 in bits [3:0].
- `dir`, input, 1: 1 = up, 0 = down. Present only with `BCD_UPDOWN_EN`.
- `q`, output, 4*DIGITS: current count, digit 0 in bits [3:0].
- `co`, output, 1: combinational cascade carry/borrow.
- `ovf`, output, 1: sticky wrap flag.
- `err`, output, 1: registered; set when a load contained a non-BCD digit.

## Operation
- Reset (asserted low): `q`=0, `ovf`=0, `err`=0, immediately and independent of `clk`. Deassertion takes effect at the next rising edge.
- Priority per edge: `load` > `en` > hold.
- Load:
  - Each digit of `d` is copied to `q`; any digit >9 is stored as 0.
  - `err` is set to 1 if any digit was >9, otherwise cleared to 0.
  - `ovf` is cleared. `en` is ignored that cycle.
- Count up:
  - Digit 0 increments 0..9 and wraps to 0.
  - Digit k increments only when all lower digits are 9 and `en`=1.
  - Full-scale 10^DIGITS−1 (all 9s) wraps to 0 and sets `ovf`.
- Count down (macro only):
  - Digit 0 decrements 9..0 and wraps to 9.
  - Digit k decrements only when all lower digits are 0.
  - 0 wraps to all 9s and sets `ovf`.
- `co`:
  - Up: `en` & all digits 9.
  - Down: `en` & all digits 0.
  - `load`=1 forces `co`=0.
  - Chained units connect `co` to the next unit's `en`.
- `ovf` and `err` stay set until the next load or reset; counting does not clear them.
- Hold: with `en`=0 and `load`=0, all registers keep their value.
- Non-BCD digit states cannot occur in `q` by construction.

## Timing
- Load and count latency: 1 clock; `q` reflects the action after the rising edge.
- `ovf` is set on the same edge as the wrap.
- `co` is combinational from `q`, `en`, `dir` and `load`, valid in the same cycle. Cascaded units therefore step on the same edge.
- Reset asserted mid-count aborts the count immediately. No pending step survives reset.
- `dir` change takes effect on the next enabled edge. No dead cycle.
- `dir` toggling at a wrap boundary: the direction sampled on that edge decides the wrap.

## Configuration
- `BCD_UPDOWN_EN` defined:
  - The `dir` port exists.
  - Digits support decrement and borrow.
  - `co` follows `dir`.
- `BCD_UPDOWN_EN` undefined:
  - No `dir` port; the counter is up-only.
  - Down logic is not synthesised.
  - All other behaviour is identical.

## Structure
- Package `bcd_pkg`:
  - `bcd_digit_t` (4-bit logic).
  - Constants `BCD_MAX`=4'd9 and `BCD_MIN`=4'd0.
  - Function `bcd_valid()` for the load check.
- Sub-module `bcd_digit`:
  - One decade, instantiated DIGITS times via generate.
  - Inputs: step, dir, load, load value.
  - Outputs: digit value, terminal flag (at 9 up / 0 down).
  - Top level chains the terminal flags into a ripple-free AND-prefix for the step enables and `co`.

## Test plan
- Reset, then `en`=1 for 12 cycles, DIGITS=4 → `q` = 0x0012, `ovf`=0, `co`=0 throughout.
- Load 0x9998, `en`=1 for 2 cycles → `q` 0x9999 with `co`=1, then 0x0000 with `ovf`=1 sticky. Next load clears `ovf`.
- Load `d`=0x12A4 → `q`=0x1204, `err`=1. Subsequent load 0x0005 → `err`=0.
- `BCD_UPDOWN_EN`, `dir`=0, load 0x0001, `en` for 2 cycles → 0x0000 with `co`=1, then 0x9999 with `ovf`=1.
- Reset pulsed low mid-count at `q`=0x0457, asynchronous to `clk` → `q`=0 before the next edge. Counting resumes from 0x0001 one edge after release.
- `load` and `en` both high with `d`=0x0300 → `q`=0x0300, no increment, `co`=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, decade limits and load-value check for the bcd_counter_n family.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic logic bcd_valid(input bcd_digit_t v);
        return (v <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade with load and step; down counting only when BCD_UPDOWN_EN is defined.
// Latency: 1 clock from step/load to val; term is combinational from val (and dir).
// Backpressure: none; the parent gates step so the decade moves only when told to.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
`ifdef BCD_UPDOWN_EN
    input  logic       dir,
`endif
    input  logic       load,
    input  bcd_digit_t ld_val,
    output bcd_digit_t val,
    output logic       term
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            val <= BCD_MIN;
        end else if (load) begin
            // Illegal load digits collapse to 0 so q never holds a non-BCD state.
            val <= bcd_valid(ld_val) ? ld_val : BCD_MIN;
        end else if (step) begin
`ifdef BCD_UPDOWN_EN
            if (dir) begin
                val <= (val == BCD_MAX) ? BCD_MIN : val + 4'd1;
            end else begin
                val <= (val == BCD_MIN) ? BCD_MAX : val - 4'd1;
            end
`else
            val <= (val == BCD_MAX) ? BCD_MIN : val + 4'd1;
`endif
        end
    end

`ifdef BCD_UPDOWN_EN
    assign term = dir ? (val == BCD_MAX) : (val == BCD_MIN);
`else
    assign term = (val == BCD_MAX);
`endif

endmodule

// File: rtl/bcd_counter_n.sv
// N-decade BCD counter with load, sticky ovf/err and cascade co; up/down when BCD_UPDOWN_EN is defined.
// Latency: 1 clock for load/count; co is combinational in the same cycle.
// Backpressure: none; en gates each step, co feeds the next unit's en so cascades step together.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                load,
    input  logic [4*DIGITS-1:0] d,
`ifdef BCD_UPDOWN_EN
    input  logic                dir,
`endif
    output logic [4*DIGITS-1:0] q,
    output logic                co,
    output logic                ovf,
    output logic                err
);

    logic [DIGITS-1:0] term;
    logic [DIGITS-1:0] step;
    logic [DIGITS-1:0] bad;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        // Each decade ANDs all lower terminal flags directly, so no carry ripples digit to digit.
        localparam logic [DIGITS-1:0] LOW = DIGITS'((64'd1 << k) - 64'd1);

        assign step[k] = en & ~load & (&(term | ~LOW));
        assign bad[k]  = ~bcd_valid(d[4*k +: 4]);

        bcd_digit u_dig (
            .clk    (clk),
            .reset  (reset),
            .step   (step[k]),
`ifdef BCD_UPDOWN_EN
            .dir    (dir),
`endif
            .load   (load),
            .ld_val (d[4*k +: 4]),
            .val    (q[4*k +: 4]),
            .term   (term[k])
        );
    end

    assign co = en & ~load & (&term);

    // co is exactly the wrap condition, so it also sets the sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
            err <= 1'b0;
        end else if (load) begin
            ovf <= 1'b0;
            err <= |bad;
        end else if (co) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Randomised bench for bcd_counter_n against an integer-valued reference model, plus directed literal checks.
module tb_bcd_counter_n;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MAXV   = 10 ** DIGITS - 1;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         en    = 1'b0;
    logic         load  = 1'b0;
    logic [W-1:0] d     = '0;
`ifdef BCD_UPDOWN_EN
    logic         dir   = 1'b1;
`endif
    logic [W-1:0] q;
    logic         co;
    logic         ovf;
    logic         err;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    int m_cnt = 0;
    bit m_ovf = 1'b0;
    bit m_err = 1'b0;

    bcd_counter_n #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .load  (load),
        .d     (d),
`ifdef BCD_UPDOWN_EN
        .dir   (dir),
`endif
        .q     (q),
        .co    (co),
        .ovf   (ovf),
        .err   (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit model_up();
`ifdef BCD_UPDOWN_EN
        return dir;
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit model_co();
        if (!en || load) return 1'b0;
        return model_up() ? (m_cnt == MAXV) : (m_cnt == 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the count as a plain integer in 0..10^DIGITS-1.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt = 0;
            m_ovf = 1'b0;
            m_err = 1'b0;
        end else if (load) begin
            int v, p;
            v = 0;
            p = 1;
            m_err = 1'b0;
            for (int k = 0; k < DIGITS; k++) begin
                int dg;
                dg = int'(d[4*k +: 4]);
                if (dg > 9) begin
                    dg = 0;
                    m_err = 1'b1;
                end
                v = v + dg * p;
                p = p * 10;
            end
            m_cnt = v;
            m_ovf = 1'b0;
        end else if (en) begin
            if (model_up()) begin
                if (m_cnt == MAXV) begin
                    m_cnt = 0;
                    m_ovf = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                if (m_cnt == 0) begin
                    m_cnt = MAXV;
                    m_ovf = 1'b1;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("q_model",   32'(q),   32'(to_bcd(m_cnt)));
            chk("ovf_model", 32'(ovf), 32'(m_ovf));
            chk("err_model", 32'(err), 32'(m_err));
            chk("co_model",  32'(co),  32'(model_co()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1;
        d    = v;
        tick();
        load = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_d();
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            int s;
            s = int'($urandom_range(0, 15));
            if (s < 5)       r[4*k +: 4] = 4'd9;
            else if (s < 10) r[4*k +: 4] = 4'd0;
            else if (s < 15) r[4*k +: 4] = 4'($urandom_range(0, 9));
            else             r[4*k +: 4] = 4'($urandom_range(10, 15));
        end
        return r;
    endfunction

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("reset_q",   32'(q),   32'h0);
        chk("reset_ovf", 32'(ovf), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        chk_on = 1'b1;
        #9 reset = 1'b1;

        en = 1'b1;
        repeat (12) tick();
        chk("count12_q",   32'(q),   32'h0012);
        chk("count12_ovf", 32'(ovf), 32'h0);
        en = 1'b0;

        do_load(16'h9998);
        en = 1'b1;
        tick();
        chk("full_q",  32'(q),  32'h9999);
        chk("full_co", 32'(co), 32'h1);
        tick();
        chk("wrap_q",   32'(q),   32'h0000);
        chk("wrap_ovf", 32'(ovf), 32'h1);
        en = 1'b0;
        repeat (3) tick();
        chk("ovf_sticky", 32'(ovf), 32'h1);
        do_load(16'h0003);
        chk("ovf_cleared", 32'(ovf), 32'h0);

        do_load(16'h12A4);
        chk("badload_q",   32'(q),   32'h1204);
        chk("badload_err", 32'(err), 32'h1);
        do_load(16'h0005);
        chk("goodload_q",   32'(q),   32'h0005);
        chk("goodload_err", 32'(err), 32'h0);

        en = 1'b1;
        do_load(16'h0300);
        chk("load_en_q", 32'(q), 32'h0300);
        load = 1'b1;
        #1;
        chk("load_forces_co0", 32'(co), 32'h0);
        load = 1'b0;
        en   = 1'b0;
        tick();

`ifdef BCD_UPDOWN_EN
        dir = 1'b0;
        do_load(16'h0001);
        en = 1'b1;
        tick();
        chk("down_zero_q",  32'(q),  32'h0000);
        chk("down_zero_co", 32'(co), 32'h1);
        tick();
        chk("down_wrap_q",   32'(q),   32'h9999);
        chk("down_wrap_ovf", 32'(ovf), 32'h1);
        en  = 1'b0;
        dir = 1'b1;
        tick();
`endif

        do_load(16'h045F);
        chk("pre_rst_err", 32'(err), 32'h1);
        en = 1'b1;
        repeat (7) tick();
        chk("pre_rst_q", 32'(q), 32'h0457);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_q",   32'(q),   32'h0);
        chk("async_rst_err", 32'(err), 32'h0);
        #2 reset = 1'b1;
        tick();
        chk("resume_q", 32'(q), 32'h0001);

        for (int i = 0; i < 3000; i++) begin
            load = ($urandom_range(0, 11) == 0);
            en   = ($urandom_range(0, 3) != 0);
            d    = rnd_d();
`ifdef BCD_UPDOWN_EN
            if ($urandom_range(0, 7) == 0) dir = ~dir;
`endif
            tick();
        end
        load = 1'b0;
        en   = 1'b0;
        tick();
        chk_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
